// File: rtl/rbm_sched_pkg.sv
// Shared types for the RBM batch scheduler: FSM state encoding, core memory-window
// select codes, and the frame-buffer element address helper.
package rbm_sched_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LD_REQ,
        ST_LD_WAIT,
        ST_LD_WR,
        ST_KICK,
        ST_RUN,
        ST_RELEASE,
        ST_NEXT,
        ST_ABORT,
        ST_DONE,
        ST_ERR
    } sched_st_t;

    // Memory-window select codes, identical to the core CSR map.
    localparam logic [2:0] MEM_SEL_V0    = 3'd0;
    localparam logic [2:0] MEM_SEL_H0    = 3'd1;
    localparam logic [2:0] MEM_SEL_V1    = 3'd2;
    localparam logic [2:0] MEM_SEL_H1    = 3'd3;
    localparam logic [2:0] MEM_SEL_W     = 3'd4;
    localparam logic [2:0] MEM_SEL_B_VIS = 3'd5;
    localparam logic [2:0] MEM_SEL_B_HID = 3'd6;

    function automatic logic [31:0] elem_addr(input logic [15:0] frame,
                                              input logic [15:0] idx,
                                              input int unsigned dim);
        return (32'(frame) * 32'(dim)) + 32'(idx);
    endfunction

    function automatic logic is_active(input sched_st_t st);
        return !(st == ST_IDLE || st == ST_DONE || st == ST_ERR);
    endfunction

endpackage

// File: rtl/rbm_batch_sched.sv
// Epoch/frame scheduler for the CD-1 RBM core: loads each frame into v0 through the
// memory window, kicks one CD-1 step, and iterates frames x epochs with a watchdog.
//
// state      | meaning
// -----------+---------------------------------------------------------------
// IDLE       | waiting for cfg_start
// LD_REQ     | frame-buffer read request for element i (fb_req high)
// LD_WAIT    | waiting for fb_rvalid
// LD_WR      | v0[i] write strobe high
// KICK       | raise core_start, clear watchdog
// RUN        | core running, watchdog counting
// RELEASE    | core_start dropped, waiting for core idle
// NEXT       | advance frame / epoch
// ABORT      | abandoned, waiting for core idle
// DONE       | schedule complete (sticky done)
// ERR        | illegal config or watchdog expiry (sticky err)
module rbm_batch_sched
    import rbm_sched_pkg::*;
#(
    parameter int unsigned I_DIM     = 64,
    parameter int unsigned TIMEOUT_W = 24
) (
    input  logic                 ACLK,
    input  logic                 ARESETn,
    input  logic                 cfg_start,
    input  logic                 cfg_abort,
    input  logic [15:0]          cfg_n_frames,
    input  logic [15:0]          cfg_epochs,
    input  logic [TIMEOUT_W-1:0] cfg_timeout,
    output logic                 fb_req,
    output logic [31:0]          fb_addr,
    input  logic                 fb_rvalid,
    input  logic [7:0]           fb_rdata,
    output logic                 core_mem_wen,
    output logic [2:0]           core_mem_sel,
    output logic [31:0]          core_mem_addr,
    output logic [31:0]          core_mem_wdata,
    output logic                 core_start,
    input  logic                 core_busy,
    input  logic                 core_done,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [15:0]          frame_idx,
    output logic [15:0]          epoch_idx,
    output logic                 batch_pulse,
    output logic                 irq
);

    localparam logic [15:0] LAST_I = 16'(I_DIM - 1);

    sched_st_t            state_q;
    logic [15:0]          i_q;
    logic [15:0]          frame_q;
    logic [15:0]          epoch_q;
    logic [TIMEOUT_W-1:0] wdog_q;
    logic [TIMEOUT_W-1:0] wdog_d;
    logic                 fb_req_q;
    logic [31:0]          fb_addr_q;
    logic                 mem_wen_q;
    logic [31:0]          mem_addr_q;
    logic [31:0]          mem_wdata_q;
    logic                 core_start_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 err_q;
    logic                 batch_pulse_q;
    logic                 irq_q;

    assign wdog_d = wdog_q + 1'b1;

    // Strobes and pulses are raised on the transition into the state they belong
    // to, so every output comes straight from a flop.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q       <= ST_IDLE;
            i_q           <= '0;
            frame_q       <= '0;
            epoch_q       <= '0;
            wdog_q        <= '0;
            fb_req_q      <= 1'b0;
            fb_addr_q     <= '0;
            mem_wen_q     <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            core_start_q  <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            batch_pulse_q <= 1'b0;
            irq_q         <= 1'b0;
        end else begin
            fb_req_q      <= 1'b0;
            mem_wen_q     <= 1'b0;
            batch_pulse_q <= 1'b0;
            irq_q         <= 1'b0;

            if (cfg_abort && is_active(state_q) && state_q != ST_ABORT) begin
                core_start_q <= 1'b0;
                state_q      <= ST_ABORT;
            end else begin
                case (state_q)
                    ST_IDLE, ST_DONE, ST_ERR: begin
                        if (cfg_start) begin
                            done_q <= 1'b0;
                            if (cfg_n_frames == 16'd0 || cfg_epochs == 16'd0) begin
                                err_q   <= 1'b1;
                                irq_q   <= 1'b1;
                                state_q <= ST_ERR;
                            end else begin
                                err_q     <= 1'b0;
                                i_q       <= '0;
                                frame_q   <= '0;
                                epoch_q   <= '0;
                                wdog_q    <= '0;
                                fb_req_q  <= 1'b1;
                                fb_addr_q <= elem_addr(16'd0, 16'd0, I_DIM);
                                busy_q    <= 1'b1;
                                state_q   <= ST_LD_REQ;
                            end
                        end
                    end
                    ST_LD_REQ: state_q <= ST_LD_WAIT;
                    ST_LD_WAIT: begin
                        if (fb_rvalid) begin
                            mem_wen_q   <= 1'b1;
                            mem_addr_q  <= {16'b0, i_q};
                            mem_wdata_q <= {{24{fb_rdata[7]}}, fb_rdata};
                            state_q     <= ST_LD_WR;
                        end
                    end
                    ST_LD_WR: begin
                        if (i_q == LAST_I) begin
                            i_q     <= '0;
                            state_q <= ST_KICK;
                        end else begin
                            i_q       <= i_q + 16'd1;
                            fb_req_q  <= 1'b1;
                            fb_addr_q <= elem_addr(frame_q, i_q + 16'd1, I_DIM);
                            state_q   <= ST_LD_REQ;
                        end
                    end
                    ST_KICK: begin
                        core_start_q <= 1'b1;
                        wdog_q       <= '0;
                        state_q      <= ST_RUN;
                    end
                    ST_RUN: begin
                        wdog_q <= wdog_d;
                        if (core_done) begin
                            core_start_q <= 1'b0;
                            state_q      <= ST_RELEASE;
                        end else if (cfg_timeout != '0 && wdog_d == cfg_timeout) begin
                            core_start_q <= 1'b0;
                            err_q        <= 1'b1;
                            irq_q        <= 1'b1;
                            busy_q       <= 1'b0;
                            state_q      <= ST_ERR;
                        end
                    end
                    ST_RELEASE: begin
                        if (!core_busy) state_q <= ST_NEXT;
                    end
                    ST_NEXT: begin
                        if (frame_q == cfg_n_frames - 16'd1) begin
                            frame_q       <= '0;
                            batch_pulse_q <= 1'b1;
                            if (epoch_q == cfg_epochs - 16'd1) begin
                                done_q  <= 1'b1;
                                irq_q   <= 1'b1;
                                busy_q  <= 1'b0;
                                state_q <= ST_DONE;
                            end else begin
                                epoch_q   <= epoch_q + 16'd1;
                                fb_req_q  <= 1'b1;
                                fb_addr_q <= elem_addr(16'd0, 16'd0, I_DIM);
                                state_q   <= ST_LD_REQ;
                            end
                        end else begin
                            frame_q   <= frame_q + 16'd1;
                            fb_req_q  <= 1'b1;
                            fb_addr_q <= elem_addr(frame_q + 16'd1, 16'd0, I_DIM);
                            state_q   <= ST_LD_REQ;
                        end
                    end
                    ST_ABORT: begin
                        if (!core_busy) begin
                            busy_q  <= 1'b0;
                            state_q <= ST_IDLE;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign fb_req         = fb_req_q;
    assign fb_addr        = fb_addr_q;
    assign core_mem_wen   = mem_wen_q;
    assign core_mem_sel   = MEM_SEL_V0;
    assign core_mem_addr  = mem_addr_q;
    assign core_mem_wdata = mem_wdata_q;
    assign core_start     = core_start_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign err            = err_q;
    assign frame_idx      = frame_q;
    assign epoch_idx      = epoch_q;
    assign batch_pulse    = batch_pulse_q;
    assign irq            = irq_q;

endmodule

// File: tb/tb_rbm_batch_sched.sv
// Directed bench for rbm_batch_sched with a 2-cycle frame-buffer model and a core stub.
module tb_rbm_batch_sched;

    localparam int I_DIM  = 4;
    localparam int TW     = 24;
    localparam int CORE_N = 5;

    logic          ACLK = 1'b0;
    logic          ARESETn = 1'b0;
    logic          cfg_start = 1'b0;
    logic          cfg_abort = 1'b0;
    logic [15:0]   cfg_n_frames = 16'd0;
    logic [15:0]   cfg_epochs = 16'd0;
    logic [TW-1:0] cfg_timeout = '0;
    logic          fb_req;
    logic [31:0]   fb_addr;
    logic          fb_rvalid = 1'b0;
    logic [7:0]    fb_rdata = 8'd0;
    logic          core_mem_wen;
    logic [2:0]    core_mem_sel;
    logic [31:0]   core_mem_addr;
    logic [31:0]   core_mem_wdata;
    logic          core_start;
    logic          core_busy = 1'b0;
    logic          core_done = 1'b0;
    logic          busy, done, err, batch_pulse, irq;
    logic [15:0]   frame_idx, epoch_idx;

    int n_cmp = 0;
    int n_bad = 0;

    rbm_batch_sched #(.I_DIM(I_DIM), .TIMEOUT_W(TW)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn), .cfg_start(cfg_start), .cfg_abort(cfg_abort),
        .cfg_n_frames(cfg_n_frames), .cfg_epochs(cfg_epochs), .cfg_timeout(cfg_timeout),
        .fb_req(fb_req), .fb_addr(fb_addr), .fb_rvalid(fb_rvalid), .fb_rdata(fb_rdata),
        .core_mem_wen(core_mem_wen), .core_mem_sel(core_mem_sel),
        .core_mem_addr(core_mem_addr), .core_mem_wdata(core_mem_wdata),
        .core_start(core_start), .core_busy(core_busy), .core_done(core_done),
        .busy(busy), .done(done), .err(err), .frame_idx(frame_idx),
        .epoch_idx(epoch_idx), .batch_pulse(batch_pulse), .irq(irq)
    );

    always #5 ACLK = ~ACLK;

    // Frame buffer (data = fb_base + element address, 2 cycles after fb_req) and core stub.
    logic [7:0]  fb_base = 8'hF0;
    bit          never_done = 1'b0;
    bit          hold_busy = 1'b0;
    int          fb_pend = 0;
    logic [31:0] fb_pend_addr = '0;
    int          core_cnt = 0;

    always @(negedge ACLK) begin
        fb_rvalid = 1'b0;
        if (fb_pend > 0) begin
            fb_pend = fb_pend - 1;
            if (fb_pend == 0) begin
                fb_rvalid = 1'b1;
                fb_rdata  = fb_base + fb_pend_addr[7:0];
            end
        end
        if (fb_req) begin
            fb_pend      = 2;
            fb_pend_addr = fb_addr;
        end
        if (core_start) begin
            core_busy = 1'b1;
            if (!never_done) begin
                if (core_cnt == CORE_N) core_done = 1'b1;
                else core_cnt = core_cnt + 1;
            end
        end else begin
            core_done = 1'b0;
            core_cnt  = 0;
            if (!hold_busy) core_busy = 1'b0;
        end
    end

    // Activity logs, sampled mid-cycle.
    logic [31:0] req_log   [64];
    logic [31:0] wr_addr   [64];
    logic [31:0] wr_data   [64];
    logic [15:0] st_frame  [64];
    logic [15:0] st_epoch  [64];
    int req_cnt, wr_cnt, start_cnt, start_hi, batch_cnt, irq_cnt, sel_bad;
    bit start_prev;

    always @(negedge ACLK) begin
        if (fb_req) begin
            if (req_cnt < 64) req_log[req_cnt] = fb_addr;
            req_cnt = req_cnt + 1;
        end
        if (core_mem_wen) begin
            if (wr_cnt < 64) begin
                wr_addr[wr_cnt] = core_mem_addr;
                wr_data[wr_cnt] = core_mem_wdata;
            end
            wr_cnt = wr_cnt + 1;
            if (core_mem_sel != 3'd0) sel_bad = sel_bad + 1;
        end
        if (core_start && !start_prev) begin
            if (start_cnt < 64) begin
                st_frame[start_cnt] = frame_idx;
                st_epoch[start_cnt] = epoch_idx;
            end
            start_cnt = start_cnt + 1;
        end
        start_prev = core_start;
        if (core_start) start_hi = start_hi + 1;
        if (batch_pulse) batch_cnt = batch_cnt + 1;
        if (irq) irq_cnt = irq_cnt + 1;
    end

    function automatic logic [138:0] all_outs();
        return {fb_req, fb_addr, core_mem_wen, core_mem_sel, core_mem_addr, core_mem_wdata,
                core_start, busy, done, err, frame_idx, epoch_idx, batch_pulse, irq};
    endfunction

    task automatic clear_logs();
        @(posedge ACLK);
        req_cnt = 0; wr_cnt = 0; start_cnt = 0; start_hi = 0;
        batch_cnt = 0; irq_cnt = 0; sel_bad = 0; start_prev = core_start;
    endtask

    task automatic pulse_start();
        @(negedge ACLK);
        cfg_start = 1'b1;
        @(negedge ACLK);
        cfg_start = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n;
        n = 0;
        while (busy && n < budget) begin
            @(negedge ACLK);
            n++;
        end
        n_cmp++;
        if (busy) begin
            n_bad++;
            $display("FAIL %s: busy still %0b after %0d cycles, required 0", name, busy, budget);
        end
        repeat (2) @(negedge ACLK);
    endtask

    task automatic wait_core_start(input int budget, input string name);
        int n;
        n = 0;
        while (!core_start && n < budget) begin
            @(negedge ACLK);
            n++;
        end
        n_cmp++;
        if (!core_start) begin
            n_bad++;
            $display("FAIL %s: core_start never rose within %0d cycles", name, budget);
        end
    endtask

    task automatic test_reset();
        #1;
        n_cmp++;
        if (all_outs() !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %h, required 0", all_outs());
        end
        repeat (3) @(negedge ACLK);
        ARESETn = 1'b1;
        repeat (3) @(negedge ACLK);
        n_cmp++;
        if (all_outs() !== '0) begin
            n_bad++;
            $display("FAIL post_reset_idle: got %h, required 0", all_outs());
        end
    endtask

    task automatic test_two_frames();
        logic [7:0] b;
        fb_base = 8'hF0; never_done = 1'b0; hold_busy = 1'b0;
        cfg_n_frames = 16'd2; cfg_epochs = 16'd1; cfg_timeout = '0;
        clear_logs();
        pulse_start();
        wait_idle(2000, "two_frames_finish");
        n_cmp++;
        if (wr_cnt !== 8) begin
            n_bad++; $display("FAIL tf_write_count: got %0d, required 8", wr_cnt);
        end
        for (int k = 0; k < 8; k++) begin
            b = 8'hF0 + 8'(k);
            n_cmp++;
            if (wr_addr[k] !== 32'(k % 4) || wr_data[k] !== {{24{b[7]}}, b}) begin
                n_bad++;
                $display("FAIL tf_write[%0d]: got addr %h data %h, required addr %h data %h",
                         k, wr_addr[k], wr_data[k], 32'(k % 4), {{24{b[7]}}, b});
            end
            n_cmp++;
            if (req_log[k] !== 32'(k)) begin
                n_bad++; $display("FAIL tf_fb_addr[%0d]: got %h, required %h", k, req_log[k], 32'(k));
            end
        end
        n_cmp++;
        if (start_cnt !== 2 || batch_cnt !== 1 || irq_cnt !== 1 || sel_bad !== 0) begin
            n_bad++;
            $display("FAIL tf_counts: starts %0d batch %0d irq_cycles %0d sel_bad %0d, required 2 1 1 0",
                     start_cnt, batch_cnt, irq_cnt, sel_bad);
        end
        n_cmp++;
        if ({done, err, busy} !== 3'b100 || frame_idx !== 16'd0 || epoch_idx !== 16'd0) begin
            n_bad++;
            $display("FAIL tf_status: done/err/busy %b frame %0d epoch %0d, required 100 0 0",
                     {done, err, busy}, frame_idx, epoch_idx);
        end
    endtask

    task automatic test_multi_epoch();
        fb_base = 8'h10;
        cfg_n_frames = 16'd3; cfg_epochs = 16'd2; cfg_timeout = '0;
        clear_logs();
        pulse_start();
        repeat (2) @(negedge ACLK);
        n_cmp++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            n_bad++; $display("FAIL me_start_clears_done: done %b busy %b, required 0 1", done, busy);
        end
        wait_idle(4000, "multi_epoch_finish");
        n_cmp++;
        if (start_cnt !== 6 || batch_cnt !== 2 || irq_cnt !== 1 || wr_cnt !== 24 || req_cnt !== 24) begin
            n_bad++;
            $display("FAIL me_counts: starts %0d batch %0d irq %0d writes %0d reqs %0d, required 6 2 1 24 24",
                     start_cnt, batch_cnt, irq_cnt, wr_cnt, req_cnt);
        end
        for (int j = 0; j < 6; j++) begin
            n_cmp++;
            if (st_epoch[j] !== 16'(j / 3) || st_frame[j] !== 16'(j % 3)) begin
                n_bad++;
                $display("FAIL me_start_idx[%0d]: epoch %0d frame %0d, required %0d %0d",
                         j, st_epoch[j], st_frame[j], j / 3, j % 3);
            end
        end
        for (int k = 0; k < 24; k++) begin
            n_cmp++;
            if (req_log[k] !== 32'(k % 12) || wr_data[k] !== 32'(8'h10 + 8'(k % 12))) begin
                n_bad++;
                $display("FAIL me_elem[%0d]: fb_addr %h wdata %h, required %h %h",
                         k, req_log[k], wr_data[k], 32'(k % 12), 32'(8'h10 + 8'(k % 12)));
            end
        end
        n_cmp++;
        if (done !== 1'b1 || epoch_idx !== 16'd1 || frame_idx !== 16'd0) begin
            n_bad++;
            $display("FAIL me_final: done %b epoch %0d frame %0d, required 1 1 0", done, epoch_idx, frame_idx);
        end
    endtask

    task automatic test_bad_config();
        cfg_n_frames = 16'd2; cfg_epochs = 16'd0;
        clear_logs();
        pulse_start();
        n_cmp++;
        if (err !== 1'b1 || irq !== 1'b1 || done !== 1'b0) begin
            n_bad++; $display("FAIL bc_err_irq: err %b irq %b done %b, required 1 1 0", err, irq, done);
        end
        @(negedge ACLK);
        n_cmp++;
        if (irq !== 1'b0 || err !== 1'b1) begin
            n_bad++; $display("FAIL bc_irq_pulse: irq %b err %b, required 0 1", irq, err);
        end
        repeat (4) @(negedge ACLK);
        n_cmp++;
        if (req_cnt !== 0 || start_cnt !== 0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL bc_no_activity: reqs %0d starts %0d busy %b, required 0 0 0", req_cnt, start_cnt, busy);
        end
    endtask

    task automatic test_timeout();
        fb_base = 8'hF0; never_done = 1'b1;
        cfg_n_frames = 16'd1; cfg_epochs = 16'd1; cfg_timeout = 24'd100;
        clear_logs();
        pulse_start();
        n_cmp++;
        if (err !== 1'b0 || busy !== 1'b1) begin
            n_bad++; $display("FAIL to_start_clears_err: err %b busy %b, required 0 1", err, busy);
        end
        wait_idle(1000, "timeout_finish");
        n_cmp++;
        if (start_hi !== 100 || start_cnt !== 1) begin
            n_bad++; $display("FAIL to_start_cycles: high %0d starts %0d, required 100 1", start_hi, start_cnt);
        end
        n_cmp++;
        if (err !== 1'b1 || done !== 1'b0 || irq_cnt !== 1 || core_start !== 1'b0) begin
            n_bad++;
            $display("FAIL to_status: err %b done %b irq %0d core_start %b, required 1 0 1 0",
                     err, done, irq_cnt, core_start);
        end
        never_done = 1'b0;
        cfg_timeout = '0;
    endtask

    task automatic test_abort();
        int n;
        cfg_n_frames = 16'd1; cfg_epochs = 16'd1;
        clear_logs();
        pulse_start();
        n = 0;
        while (!fb_req && n < 10) begin
            @(negedge ACLK);
            n++;
        end
        @(negedge ACLK);
        cfg_abort = 1'b1;
        @(negedge ACLK);
        cfg_abort = 1'b0;
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++; $display("FAIL ab_wait_in_abort: busy %b, required 1", busy);
        end
        @(negedge ACLK);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++; $display("FAIL ab_wait_idle: busy %b, required 0", busy);
        end
        repeat (4) @(negedge ACLK);
        n_cmp++;
        if (wr_cnt !== 0 || start_cnt !== 0 || irq_cnt !== 0 || done !== 1'b0 || err !== 1'b0) begin
            n_bad++;
            $display("FAIL ab_wait_effects: writes %0d starts %0d irq %0d done %b err %b, required 0 0 0 0 0",
                     wr_cnt, start_cnt, irq_cnt, done, err);
        end

        never_done = 1'b1; hold_busy = 1'b1;
        clear_logs();
        pulse_start();
        wait_core_start(100, "ab_run_kick");
        repeat (3) @(negedge ACLK);
        cfg_abort = 1'b1;
        @(negedge ACLK);
        cfg_abort = 1'b0;
        n_cmp++;
        if (core_start !== 1'b0 || busy !== 1'b1) begin
            n_bad++; $display("FAIL ab_run_drop: core_start %b busy %b, required 0 1", core_start, busy);
        end
        repeat (5) @(negedge ACLK);
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++; $display("FAIL ab_run_hold: busy %b while core busy, required 1", busy);
        end
        hold_busy = 1'b0;
        wait_idle(20, "ab_run_release");
        n_cmp++;
        if (irq_cnt !== 0 || done !== 1'b0 || err !== 1'b0) begin
            n_bad++; $display("FAIL ab_run_effects: irq %0d done %b err %b, required 0 0 0", irq_cnt, done, err);
        end
        never_done = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        never_done = 1'b1;
        cfg_n_frames = 16'd1; cfg_epochs = 16'd1;
        clear_logs();
        pulse_start();
        wait_core_start(100, "rst_kick");
        @(negedge ACLK);
        #2 ARESETn = 1'b0;
        #1;
        n_cmp++;
        if (all_outs() !== '0) begin
            n_bad++; $display("FAIL rst_async_outputs: got %h, required 0", all_outs());
        end
        repeat (2) @(negedge ACLK);
        ARESETn = 1'b1;
        never_done = 1'b0;
        clear_logs();
        repeat (10) @(negedge ACLK);
        n_cmp++;
        if (busy !== 1'b0 || req_cnt !== 0 || start_cnt !== 0) begin
            n_bad++;
            $display("FAIL rst_stays_idle: busy %b reqs %0d starts %0d, required 0 0 0", busy, req_cnt, start_cnt);
        end
        pulse_start();
        wait_idle(1000, "rst_rerun_finish");
        n_cmp++;
        if (done !== 1'b1 || start_cnt !== 1 || wr_cnt !== 4 || irq_cnt !== 1) begin
            n_bad++;
            $display("FAIL rst_rerun: done %b starts %0d writes %0d irq %0d, required 1 1 4 1",
                     done, start_cnt, wr_cnt, irq_cnt);
        end
    endtask

    initial begin
        req_cnt = 0; wr_cnt = 0; start_cnt = 0; start_hi = 0;
        batch_cnt = 0; irq_cnt = 0; sel_bad = 0; start_prev = 1'b0;
        test_reset();
        test_two_frames();
        test_multi_epoch();
        test_bad_config();
        test_timeout();
        test_abort();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_time_limit: bench did not finish within 2 ms simulated");
        $fatal(1);
    end

endmodule
